// File: rtl/znc_flag_sequencer.sv
// znc_flag_sequencer: issue-side sequencer for CMP/SET/CLR flag instructions.
// Owns the architectural ZNC flag register and arbitrates it against the
// external flag_ld writeback path.
module znc_flag_sequencer #(
    parameter int unsigned DW        = 16,
    parameter logic [2:0]  RESET_ZNC = 3'b000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ins_valid,
    output logic          ins_ready,
    input  logic [15:0]   ins,
    output logic          rf_re,
    output logic [3:0]    rf_addr_a,
    output logic [3:0]    rf_addr_b,
    input  logic [DW-1:0] rf_rdata_a,
    input  logic [DW-1:0] rf_rdata_b,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [2:0]    res_znc,
    output logic [1:0]    res_op,
    output logic [2:0]    znc,
    input  logic          flag_ld,
    input  logic [2:0]    flag_ld_znc,
    output logic          flag_ld_drop,
    output logic          ins_ignored
);

    localparam int unsigned OPW  = 2;
    localparam int unsigned FLGW = 3;

    localparam logic [OPW-1:0] OP_CMP   = 2'b00;
    localparam logic [OPW-1:0] OP_SET   = 2'b01;
    localparam logic [OPW-1:0] OP_CLR   = 2'b10;
    localparam logic [OPW-1:0] OP_RSVD  = 2'b11;
    localparam logic [1:0]     CLS_FLAG = 2'b11;

    // Instruction word layout
    typedef struct packed {
        logic [1:0]      cls;
        logic [OPW-1:0]  op;
        logic [3:0]      ra;
        logic [3:0]      rb;
        logic            rsvd;
        logic [FLGW-1:0] mask;
    } ins_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    ins_t            ins_w;
    logic            is_flag;
    logic            accept;
    logic [OPW-1:0]  op_q;
    logic [FLGW-1:0] mask_q;
    logic [FLGW-1:0] exec_znc;
    logic            ins_ready_d;
    logic            rf_re_d;
    logic            res_valid_d;
    logic            unused_rsvd;

    assign ins_w       = ins_t'(ins);
    assign unused_rsvd = ins_w.rsvd;

    // Only class 11 words with a non-reserved op are flag instructions
    assign is_flag = (ins_w.cls == CLS_FLAG) && (ins_w.op != OP_RSVD);
    assign accept  = (state_q == S_IDLE) && ins_valid && is_flag;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ins_valid && is_flag) begin
                    state_d = (ins_w.op == OP_CMP) ? S_RD : S_EXEC;
                end
            end
            S_RD:   state_d = S_EXEC;
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake/strobe outputs decoded from the upcoming state, then registered
    always_comb begin
        ins_ready_d = 1'b0;
        rf_re_d     = 1'b0;
        res_valid_d = 1'b0;
        case (state_d)
            S_IDLE:  ins_ready_d = 1'b1;
            S_RD:    rf_re_d     = 1'b1;
            S_RESP:  res_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Registered handshake/strobe outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_ready <= 1'b1;
            rf_re     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            ins_ready <= ins_ready_d;
            rf_re     <= rf_re_d;
            res_valid <= res_valid_d;
        end
    end

    // New flag value computed in EXEC; SET/CLR act on the flags as they stand now
    always_comb begin
        exec_znc = znc;
        case (op_q)
            OP_CMP: begin
                exec_znc[2] = (rf_rdata_a == rf_rdata_b);
                exec_znc[1] = ($signed(rf_rdata_a) < $signed(rf_rdata_b));
                exec_znc[0] = (rf_rdata_a < rf_rdata_b);
            end
            OP_SET:  exec_znc = znc | mask_q;
            OP_CLR:  exec_znc = znc & ~mask_q;
            default: exec_znc = znc;
        endcase
    end

    // Instruction latch, flag register, result and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= OP_CMP;
            mask_q       <= '0;
            rf_addr_a    <= '0;
            rf_addr_b    <= '0;
            res_znc      <= '0;
            res_op       <= '0;
            znc          <= RESET_ZNC;
            flag_ld_drop <= 1'b0;
            ins_ignored  <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= ins_w.op;
                mask_q    <= ins_w.mask;
                rf_addr_a <= ins_w.ra;
                rf_addr_b <= ins_w.rb;
            end
            // Sequencer write on the EXEC exit edge takes priority over flag_ld
            if (state_q == S_EXEC) begin
                znc     <= exec_znc;
                res_znc <= exec_znc;
                res_op  <= op_q;
            end else if (flag_ld) begin
                znc <= flag_ld_znc;
            end
            flag_ld_drop <= (state_q == S_EXEC) && flag_ld;
            ins_ignored  <= (state_q == S_IDLE) && ins_valid && !is_flag;
        end
    end

endmodule
